md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide responder for the E stage: accepts a start pulse plus MDOp and operands,
//  holds busy for a fixed latency, then commits the result to internal HI/LO registers.
//  It also serves mfhi/mflo reads and mthi/mtlo writes. The hazard unit stalls D on (start|busy)
//  when the D-stage instruction is an MD-type instruction.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd family)
//  DIV_CYCLES   10  busy cycles for div/divu
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-low; clears all state
//  start   in   1   one-cycle request; meaningful only with MDOp = mult/multu/div/divu(/madd*)
//  MDOp    in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo,
//                   9 madd, 10 maddu, 11 msub (9-11 only with MDU_MADD_EN)
//  D1      in   32  rs operand (forwarded)
//  D2      in   32  rt operand (forwarded)
//  req     in   1   exception/interrupt flush this cycle; suppresses start and mthi/mtlo
//  busy    out  1   operation in flight
//  result  out  32  combinational: HI if MDOp=5, LO if MDOp=6, else 0
// BEHAVIOUR
//  - Reset (reset=0, async): HI=0, LO=0, counter=0, busy=0, latched op cleared. result follows HI/LO.
//  - FSM states: IDLE and RUN.
//    - IDLE -> RUN on a posedge with start=1, req=0, and MDOp in {1..4,9..11}.
//      On that edge: latch D1, D2 and MDOp; load the counter with MULT_CYCLES or DIV_CYCLES.
//    - busy = (state==RUN). The start cycle itself has busy=0; busy is high for exactly N
//      subsequent cycles.
//    - RUN: the counter decrements each edge. On the edge where the counter goes 1->0: write
//      HI/LO, go to IDLE, busy drops. The next instruction may issue start in that same cycle
//      (no bubble).
//  - Arithmetic, computed on the latched operands:
//    - mult: {HI,LO} = $signed(D1)*$signed(D2), 64-bit. multu: unsigned.
//    - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//      divu: unsigned.
//    - Divide by zero: HI and LO are left unchanged. busy still runs the full DIV_CYCLES.
//    - div 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//  - start while busy=1: ignored. The hazard unit guarantees this never happens; the unit
//    tolerates it.
//  - mthi/mtlo (MDOp 7/8): write D1 to HI/LO on the edge, only if busy=0 and req=0.
//    If busy=1 the write is dropped.
//  - mfhi/mflo: result reflects the current HI/LO combinationally, including a value committed
//    on the previous edge.
//  - req during RUN: does not cancel. The in-flight op already retired past E; it completes and
//    commits.
//  - req together with start: start is ignored, state stays IDLE, HI/LO untouched.
//  - reset asserted mid-RUN: immediate abort, all state cleared, no commit.
// CONFIGURATION
//  - MDU_MADD_EN defined: MDOp 9/10/11 are legal MULT_CYCLES ops.
//    - madd:  {HI,LO} += signed product
//    - maddu: {HI,LO} += unsigned product
//    - msub:  {HI,LO} -= signed product
//    - All use 64-bit wrap-around arithmetic, and the accumulate base is HI/LO as of commit time.
//  - MDU_MADD_EN undefined: MDOp 9-11 behave as 0 (start ignored, no busy, no state change).
// TESTING
//  1. mult D1=0xFFFFFFFE (-2), D2=3, start 1 cycle -> busy high 5 cycles;
//     then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. div D1=0xFFFFFFF9 (-7), D2=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//     Then divu of the same operands -> LO=0x7FFFFFFC, HI=1.
//  3. mthi 0x1234, then div by 0 -> busy 10 cycles; HI stays 0x1234, LO stays its prior value;
//     mfhi result=0x1234.
//  4. start=1 with req=1 (mult 5*5) -> busy stays 0, HI/LO unchanged.
//     mtlo 0xAA issued while busy -> LO unchanged.
//  5. multu 0xFFFFFFFF*0xFFFFFFFF, reset pulsed low in busy cycle 3 -> busy=0 immediately,
//     HI=LO=0, no later commit.
//  6. (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, maddu 1*1 -> HI=1, LO=0.
//     Without the macro, the same MDOp=10 start -> busy never asserts.

Source files
------------

// File: rtl/md_unit.sv
// ============================================================================
// md_unit : multiply/divide unit with HI/LO registers, fixed-latency busy.
// Optional MDU_MADD_EN enables madd/maddu/msub accumulate ops (MDOp 9-11).
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        req,
  output logic        busy,
  output logic [31:0] result
);

  localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MFHI  = 4'd5;
  localparam logic [3:0] C_OP_MFLO  = 4'd6;
  localparam logic [3:0] C_OP_MTHI  = 4'd7;
  localparam logic [3:0] C_OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] C_OP_MADD  = 4'd9;
  localparam logic [3:0] C_OP_MADDU = 4'd10;
  localparam logic [3:0] C_OP_MSUB  = 4'd11;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  logic               w_legal, w_is_div, w_start_ok, w_commit;
  logic [63:0]        w_prod_s, w_prod_u;
  logic [31:0]        w_b_safe, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic               w_div_ovf;

  always_comb begin
    w_legal  = 1'b0;
    w_is_div = 1'b0;
    case (MDOp)
      C_OP_MULT, C_OP_MULTU: w_legal = 1'b1;
      C_OP_DIV, C_OP_DIVU: begin
        w_legal  = 1'b1;
        w_is_div = 1'b1;
      end
`ifdef MDU_MADD_EN
      C_OP_MADD, C_OP_MADDU, C_OP_MSUB: w_legal = 1'b1;
`endif
      default: ;
    endcase
  end

  // A flush in the same cycle as start means the instruction never reached E.
  assign w_start_ok = start && !req && w_legal && (state_q == S_IDLE);
  assign w_commit   = (state_q == S_RUN) && (cnt_q == C_CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_start_ok) state_d = S_RUN;
      S_RUN:   if (w_commit)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
  end

  assign w_prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Divisor forced non-zero so the dividers never see x/0; zero divides do not commit.
  assign w_b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign w_div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign w_quo_s   = w_div_ovf ? 32'h8000_0000 : 32'($signed(a_q) / $signed(w_b_safe));
  assign w_rem_s   = w_div_ovf ? 32'd0         : 32'($signed(a_q) % $signed(w_b_safe));
  assign w_quo_u   = a_q / w_b_safe;
  assign w_rem_u   = a_q % w_b_safe;

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (w_start_ok) begin
      op_d  = MDOp;
      a_d   = D1;
      b_d   = D2;
      cnt_d = w_is_div ? C_CNT_W'(DIV_CYCLES) : C_CNT_W'(MULT_CYCLES);
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - C_CNT_W'(1);
    end

    if (w_commit) begin
      case (op_q)
        C_OP_MULT:  {hi_d, lo_d} = w_prod_s;
        C_OP_MULTU: {hi_d, lo_d} = w_prod_u;
        C_OP_DIV:   if (b_q != 32'd0) begin
          lo_d = w_quo_s;
          hi_d = w_rem_s;
        end
        C_OP_DIVU:  if (b_q != 32'd0) begin
          lo_d = w_quo_u;
          hi_d = w_rem_u;
        end
`ifdef MDU_MADD_EN
        C_OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + w_prod_s;
        C_OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + w_prod_u;
        C_OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - w_prod_s;
`endif
        default: ;
      endcase
    end else if ((state_q == S_IDLE) && !req) begin
      if (MDOp == C_OP_MTHI) hi_d = D1;
      if (MDOp == C_OP_MTLO) lo_d = D1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_comb begin
    case (MDOp)
      C_OP_MFHI: result = hi_q;
      C_OP_MFLO: result = lo_q;
      default:   result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit : table-driven, scoreboarded testbench for md_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  MDOp;
  logic [31:0] D1, D2;
  logic        req;
  logic        busy;
  logic [31:0] result;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MDOp   (MDOp),
    .D1     (D1),
    .D2     (D2),
    .req    (req),
    .busy   (busy),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDOp = 4'd5; #1 hi = result;
    MDOp = 4'd6; #1 lo = result;
    MDOp = 4'd0;
  endtask

  task automatic chk_hilo(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] h, l;
    read_hilo(h, l);
    chk({nm, ".hi"}, h, ehi);
    chk({nm, ".lo"}, l, elo);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    MDOp = op; D1 = val;
    tick();
    MDOp = 4'd0; D1 = 32'd0;
  endtask

  // inj=1: a stray start and an mtlo 0xAA are driven during the busy window.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] ehi,
                        input logic [31:0] elo, input int cyc, input int inj);
    exp_t e;
    int   n;
    e.hi = ehi; e.lo = elo; e.cyc = cyc;
    sb.push_back(e);
    MDOp = op; D1 = d1; D2 = d2; start = 1'b1;
    #1 chk({nm, ".busy_at_start"}, {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0; MDOp = 4'd0; D1 = 32'd0; D2 = 32'd0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (inj == 1 && n == 1) begin
        start = 1'b1; MDOp = 4'd1; D1 = 32'd7; D2 = 32'd9;
      end else if (inj == 1 && n == 2) begin
        start = 1'b0; MDOp = 4'd8; D1 = 32'hAA;
      end else begin
        start = 1'b0; MDOp = 4'd0; D1 = 32'd0;
      end
      tick();
    end
    start = 1'b0; MDOp = 4'd0; D1 = 32'd0;
    e = sb.pop_front();
    chk({nm, ".cycles"}, 32'(n), 32'(e.cyc));
    chk_hilo(nm, e.hi, e.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;

    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[2] = '{4'd4, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 10};
    vecs[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[4] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[5] = '{4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 5};
    vecs[6] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[7] = '{4'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10};

    reset = 1'b0; start = 1'b0; MDOp = 4'd0; D1 = 32'd0; D2 = 32'd0; req = 1'b0;
    #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk_hilo("reset", 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Back-to-back: each start lands in the first cycle busy is low.
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc, 0);

    // mthi then divide by zero, with stray start and mtlo during busy.
    mt(4'd7, 32'h1234);
    run_op("div0", 4'd3, 32'd55, 32'd0, 32'h1234, 32'd14, 10, 1);

    // Flush together with start, and flushed mthi.
    MDOp = 4'd1; D1 = 32'd5; D2 = 32'd5; start = 1'b1; req = 1'b1;
    tick();
    start = 1'b0; MDOp = 4'd7; D1 = 32'h5555;
    chk("req_start.busy", {31'd0, busy}, 32'd0);
    tick();
    req = 1'b0; MDOp = 4'd0; D1 = 32'd0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) n++;
      tick();
    end
    chk("req_start.busy_cycles", 32'(n), 32'd0);
    chk_hilo("req_start", 32'h1234, 32'd14);

    // Reset asserted in busy cycle 3 aborts the multu.
    MDOp = 4'd2; D1 = 32'hFFFF_FFFF; D2 = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0; MDOp = 4'd0;
    tick();
    tick();
    chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk_hilo("rst_mid", 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) n++;
      tick();
    end
    chk("rst_mid.busy_after", 32'(n), 32'd0);
    chk_hilo("rst_mid.no_commit", 32'd0, 32'd0);

    mt(4'd8, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd10, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
    run_op("msub",  4'd11, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'd3, 5, 0);
    run_op("madd",  4'd9,  32'd2, 32'hFFFF_FFFC, 32'd0, 32'hFFFF_FFFB, 5, 0);
`else
    MDOp = 4'd10; D1 = 32'd1; D2 = 32'd1; start = 1'b1;
    tick();
    start = 1'b0; MDOp = 4'd0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) n++;
      tick();
    end
    chk("maddu_off.busy_cycles", 32'(n), 32'd0);
    chk_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
